// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared mode constants and length clamp for the serial pattern detector
package seq_det_pkg;

  localparam bit MODE_MEALY  = 1'b1;
  localparam bit MODE_MOORE  = 1'b0;
  localparam bit OVERLAP_ON  = 1'b1;
  localparam bit OVERLAP_OFF = 1'b0;

  // Active length is forced into 1..max_len so the compare mask is never empty.
  function automatic int clamp_len(input int len, input int max_len);
    if (len < 1) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with clear; clear plus increment yields one
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-loadable serial bit-pattern detector with hit counter
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int           N           = 4,
  parameter logic [N-1:0] DEFAULT_PAT = 4'b1101,
  parameter bit           MEALY       = MODE_MEALY,
  parameter bit           OVERLAP     = OVERLAP_ON,
  parameter int           CNT_W       = 8,
  localparam int          LW          = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pattern,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cnt_clr,
  output logic             match_out,
  output logic [CNT_W-1:0] match_count,
  output logic [LW-1:0]    cfg_len_q
);

  logic [N-1:0]  pat_q, pat_d;
  logic [N-1:0]  hist_q, hist_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] fill_q, fill_d;
  logic [N-1:0]  mask;
  logic [N-1:0]  cand;
  logic          accept;
  logic          hit;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (int'(len_q) > i);
    end
  end

  assign cand   = {hist_q[N-2:0], in_bit};
  assign accept = in_valid & ~cfg_load;
  // fill guarantees every compared bit arrived since the last restart
  assign hit    = accept && (fill_q >= len_q - LW'(1)) && ((cand & mask) == (pat_q & mask));

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = LW'(clamp_len(int'(cfg_len), N));
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = cand;
      if (hit && (OVERLAP != OVERLAP_ON)) begin
        fill_d = '0;
      end else if (fill_q < len_q) begin
        fill_d = fill_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= DEFAULT_PAT;
      len_q  <= LW'(N);
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  generate
    if (MEALY == MODE_MEALY) begin : g_mealy
      assign match_out = hit;
    end else begin : g_moore
      logic match_q;
      logic match_d;
      assign match_d = hit;
      always_ff @(posedge clk) begin
        if (reset) begin
          match_q <= 1'b0;
        end else begin
          match_q <= match_d;
        end
      end
      assign match_out = match_q;
    end
  endgenerate

  sat_counter #(.W(CNT_W)) u_count (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (hit),
    .q     (match_count)
  );

  assign cfg_len_q = len_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - bench for seq_detector_param: Mealy/overlap and Moore/non-overlap instances
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pattern = 4'b0000;
  logic [2:0] cfg_len = 3'd0;
  logic       cnt_clr = 1'b0;

  logic       match_a, match_b;
  logic [7:0] count_a;
  logic [1:0] count_b;
  logic [2:0] len_a, len_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.N(4), .DEFAULT_PAT(4'b1101), .MEALY(1'b1), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
    .match_out(match_a), .match_count(count_a), .cfg_len_q(len_a));

  seq_detector_param #(.N(4), .DEFAULT_PAT(4'b1101), .MEALY(1'b0), .OVERLAP(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cnt_clr(cnt_clr),
    .match_out(match_b), .match_count(count_b), .cfg_len_q(len_b));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queues of bits accepted since the last restart, most recent last.
  bit         mq_a[$];
  bit         mq_b[$];
  logic [3:0] m_pat = 4'b1101;
  int         m_len = 4;
  int         m_cnt_a = 0;
  int         m_cnt_b = 0;
  bit         m_prev_b = 1'b0;
  bit         mv = 1'b0;

  function automatic bit mhit(input bit q[$], input logic [3:0] p, input int l,
                              input logic v, input logic ld, input logic b);
    if (!v || ld) return 1'b0;
    if (q.size() < l - 1) return 1'b0;
    if (b != p[0]) return 1'b0;
    for (int k = 1; k < l; k++) begin
      if (q[q.size() - k] != p[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int mclamp(input int l);
    if (l < 1) return 1;
    if (l > 4) return 4;
    return l;
  endfunction

  always @(negedge clk) begin
    bit ha, hb;
    ha = mhit(mq_a, m_pat, m_len, in_valid, cfg_load, in_bit);
    hb = mhit(mq_b, m_pat, m_len, in_valid, cfg_load, in_bit);
    if (mv) begin
      if (!reset) begin
        chk("mon_match_a", int'(match_a), int'(ha));
        chk("mon_match_b", int'(match_b), int'(m_prev_b));
      end
      chk("mon_count_a", int'(count_a), m_cnt_a);
      chk("mon_count_b", int'(count_b), m_cnt_b);
      chk("mon_len_a", int'(len_a), m_len);
      chk("mon_len_b", int'(len_b), m_len);
    end
    if (reset) begin
      mq_a.delete();
      mq_b.delete();
      m_pat = 4'b1101;
      m_len = 4;
      m_cnt_a = 0;
      m_cnt_b = 0;
      m_prev_b = 1'b0;
      mv = 1'b1;
    end else begin
      m_prev_b = hb;
      if (cnt_clr) m_cnt_a = ha ? 1 : 0;
      else if (ha && m_cnt_a < 255) m_cnt_a++;
      if (cnt_clr) m_cnt_b = hb ? 1 : 0;
      else if (hb && m_cnt_b < 3) m_cnt_b++;
      if (cfg_load) begin
        m_pat = cfg_pattern;
        m_len = mclamp(int'(cfg_len));
        mq_a.delete();
        mq_b.delete();
      end else if (in_valid) begin
        mq_a.push_back(in_bit);
        if (mq_a.size() > 4) void'(mq_a.pop_front());
        if (hb) mq_b.delete();
        else begin
          mq_b.push_back(in_bit);
          if (mq_b.size() > 4) void'(mq_b.pop_front());
        end
      end
    end
  end

  task automatic drv(input logic v, input logic b, input logic ld, input logic clr,
                     input logic [3:0] p, input logic [2:0] l);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = v;
    in_bit = b;
    cfg_load = ld;
    cnt_clr = clr;
    cfg_pattern = p;
    cfg_len = l;
    #1;
  endtask

  task automatic bitin(input logic b);
    drv(1'b1, b, 1'b0, 1'b0, 4'b0000, 3'd0);
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] s1, ea1, eb1;
    logic [9:0] s2;
    logic [3:0] s4;
    s1 = 7'b1101101;
    ea1 = 7'b0001001;
    eb1 = 7'b0000100;
    s2 = 10'b1101101101;
    s4 = 4'b1101;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_count_a", int'(count_a), 0);
    chk("reset_len_a", int'(len_a), 4);
    chk("reset_match_b", int'(match_b), 0);

    // T1: overlapping Mealy hits on bits 4 and 7; Moore non-overlap pulses after bit 4 only
    pulse_reset();
    for (int i = 6; i >= 0; i--) begin
      bitin(s1[i]);
      chk("t1_match_a", int'(match_a), int'(ea1[i]));
      chk("t1_match_b", int'(match_b), int'(eb1[i]));
    end
    idle();
    chk("t1_count_a", int'(count_a), 2);
    chk("t1_count_b", int'(count_b), 1);

    // T2: 1101101101 -> overlap 3 hits, non-overlap 2 hits
    pulse_reset();
    for (int i = 9; i >= 0; i--) bitin(s2[i]);
    idle();
    chk("t2_count_a", int'(count_a), 3);
    chk("t2_count_b", int'(count_b), 2);

    // T3: valid bubbles between bits do not break the match
    pulse_reset();
    for (int i = 3; i >= 0; i--) begin
      bitin(s4[i]);
      if (i == 0) chk("t3_match_a", int'(match_a), 1);
      idle();
      if (i == 0) chk("t3_match_b", int'(match_b), 1);
    end
    chk("t3_count_a", int'(count_a), 1);

    // T4: pattern 11, length 2; the in_bit on the load cycle is discarded
    pulse_reset();
    drv(1'b1, 1'b1, 1'b1, 1'b0, 4'b0011, 3'd2);
    chk("t4_load_match_a", int'(match_a), 0);
    bitin(1'b1);
    chk("t4_len_a", int'(len_a), 2);
    chk("t4_bit1_a", int'(match_a), 0);
    bitin(1'b1);
    chk("t4_bit2_a", int'(match_a), 1);
    bitin(1'b1);
    chk("t4_bit3_a", int'(match_a), 1);
    idle();
    chk("t4_count_a", int'(count_a), 2);
    chk("t4_count_b", int'(count_b), 1);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 3'd0);
    idle();
    chk("t4_len_clamp_lo", int'(len_a), 1);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 4'b1101, 3'd7);
    idle();
    chk("t4_len_clamp_hi", int'(len_b), 4);

    // T5: five hits saturate the 2-bit counter; clear with hit gives 1, clear alone gives 0
    pulse_reset();
    for (int r = 0; r < 5; r++) for (int i = 3; i >= 0; i--) bitin(s4[i]);
    idle();
    chk("t5_count_a", int'(count_a), 5);
    chk("t5_count_b_sat", int'(count_b), 3);
    bitin(1'b1); bitin(1'b1); bitin(1'b0);
    drv(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 3'd0);
    idle();
    chk("t5_clr_hit_a", int'(count_a), 1);
    chk("t5_clr_hit_b", int'(count_b), 1);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 3'd0);
    idle();
    chk("t5_clr_a", int'(count_a), 0);

    // T6: reset mid-pattern drops the partial match and restores the default pattern
    drv(1'b0, 1'b0, 1'b1, 1'b0, 4'b0110, 3'd3);
    bitin(1'b1); bitin(1'b1); bitin(1'b0);
    pulse_reset();
    bitin(1'b1);
    chk("t6_no_hit_a", int'(match_a), 0);
    chk("t6_len_a", int'(len_a), 4);
    for (int i = 3; i >= 0; i--) bitin(s4[i]);
    chk("t6_hit_a", int'(match_a), 1);
    idle();
    chk("t6_count_b", int'(count_b), 1);

    // Randomised traffic checked cycle by cycle against the model
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 199));
      @(posedge clk);
      #1;
      reset = (r < 2);
      cfg_load = (r >= 2 && r < 6);
      cnt_clr = (r >= 6 && r < 12);
      in_valid = ($urandom_range(0, 9) < 7);
      in_bit = $urandom_range(0, 1) == 1;
      cfg_pattern = 4'($urandom_range(0, 15));
      cfg_len = 3'($urandom_range(0, 7));
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
